// File: rtl/hamming_decoder.sv
// Hamming(7,4) decoder with single-error correction.
// The syndrome and correction are computed combinationally from the stage-1 word
// and registered into stage 2, which gives two pipeline stages with full backpressure.
// Saturating counters track words delivered and words that needed a correction.
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk_dec,
  input  logic             rst_dec_n,
  input  logic [7:1]       dec_code,
  input  logic             dec_valid,
  output logic             dec_ready,
  output logic [4:1]       dec_data,
  output logic [3:1]       dec_syndrome,
  output logic             dec_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       s1_valid;
  logic [7:1] s1_code;
  logic       s1_accept;
  logic       s2_load;
  logic       out_xfer;
  logic [3:1] syn;
  logic [7:1] fixed_code;

  // Stage 2 may load when it is empty or its word leaves this cycle.
  assign s2_load   = s1_valid && (!out_valid || out_ready);
  // Stage 1 may accept when it is empty or its word moves on this cycle.
  // Held low while reset is asserted so no word is taken during reset.
  assign dec_ready = rst_dec_n && (!s1_valid || s2_load);
  assign s1_accept = dec_valid && dec_ready;
  assign out_xfer  = out_valid && out_ready;

  // Syndrome from the stage-1 word; its value is the position of the bad bit.
  // The flipped bit is then used for data extraction.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // conditional logic, otherwise the tool infers a latch for the hold case.
    syn        = '0;
    fixed_code = s1_code;
    syn[1] = s1_code[1] ^ s1_code[3] ^ s1_code[5] ^ s1_code[7];
    syn[2] = s1_code[2] ^ s1_code[3] ^ s1_code[6] ^ s1_code[7];
    syn[3] = s1_code[4] ^ s1_code[5] ^ s1_code[6] ^ s1_code[7];
    for (int i = 1; i <= 7; i++) begin
      if (syn == 3'(i)) fixed_code[i] = ~s1_code[i];
    end
  end

  // Stage-1 valid flag: set on accept, cleared when the word moves to stage 2.
  always_ff @(posedge clk_dec) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_dec_n) begin
      s1_valid <= 1'b0;
    end else if (s1_accept) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-1 codeword register.
  // NOTE: the data register has no reset; s1_valid qualifies it, so its
  // reset value would never be observed.
  always_ff @(posedge clk_dec) begin
    if (s1_accept) s1_code <= dec_code;
  end

  // Stage-2 output register: corrected data, syndrome and error flag.
  always_ff @(posedge clk_dec) begin
    if (!rst_dec_n) begin
      out_valid    <= 1'b0;
      dec_data     <= '0;
      dec_syndrome <= '0;
      dec_err      <= 1'b0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      dec_data     <= {fixed_code[7], fixed_code[6], fixed_code[5], fixed_code[3]};
      dec_syndrome <= syn;
      dec_err      <= (syn != 3'd0);
    end else if (out_xfer) begin
      out_valid    <= 1'b0;
    end
  end

  // Saturating link-quality counters. A clear overrides a same-cycle increment.
  always_ff @(posedge clk_dec) begin
    if (!rst_dec_n || cnt_clr) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_xfer) begin
      if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
      if (dec_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder. Two instances share stimulus: the
// default 8-bit-counter build and a 2-bit-counter build for saturation checks.
// A transaction-level model predicts every output word and both counter pairs.
module tb_hamming_decoder;

  logic       clk_dec = 1'b0;
  logic       rst_dec_n;
  logic [7:1] dec_code;
  logic       dec_valid;
  logic       out_ready;
  logic       cnt_clr;

  logic       dec_ready, out_valid, dec_err;
  logic [4:1] dec_data;
  logic [3:1] dec_syndrome;
  logic [7:0] word_cnt, err_cnt;

  logic       dec_ready_s, out_valid_s, dec_err_s;
  logic [4:1] dec_data_s;
  logic [3:1] dec_syndrome_s;
  logic [1:0] word_cnt_s, err_cnt_s;

  hamming_decoder #(.CNT_W(8)) dut (
    .clk_dec(clk_dec), .rst_dec_n(rst_dec_n), .dec_code(dec_code),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
    .dec_syndrome(dec_syndrome), .dec_err(dec_err), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  hamming_decoder #(.CNT_W(2)) dut_small (
    .clk_dec(clk_dec), .rst_dec_n(rst_dec_n), .dec_code(dec_code),
    .dec_valid(dec_valid), .dec_ready(dec_ready_s), .dec_data(dec_data_s),
    .dec_syndrome(dec_syndrome_s), .dec_err(dec_err_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .word_cnt(word_cnt_s), .err_cnt(err_cnt_s)
  );

  always #5 clk_dec = ~clk_dec;

  typedef struct {
    logic [4:1] data;
    logic [3:1] syn;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   m_word = 0, m_err = 0, m_word_s = 0, m_err_s = 0;
  bit   lat_chk = 1'b0;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder from the codeword map: data at 3,5,6,7, even parity at 1,2,4.
  function automatic logic [7:1] encode(input logic [4:1] d);
    logic [7:1] c;
    c    = '0;
    c[3] = d[1]; c[5] = d[2]; c[6] = d[3]; c[7] = d[4];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // Reference decode: the syndrome is the XOR of the positions of all set bits.
  function automatic exp_t ref_decode(input logic [7:1] c_in);
    exp_t       e;
    logic [7:1] c;
    int         s;
    c = c_in;
    s = 0;
    for (int i = 1; i <= 7; i++) if (c[i]) s = s ^ i;
    if (s != 0) c[s] = ~c[s];
    e.data = {c[7], c[6], c[5], c[3]};
    e.syn  = 3'(s);
    e.err  = (s != 0);
    e.cyc  = 0;
    return e;
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  // One clock cycle: sample the handshake mid-cycle, advance the model at the edge,
  // then compare outputs and counters.
  task automatic tick();
    bit         acc, xfr, rs, clr;
    logic [7:1] code;
    exp_t       e;
    @(negedge clk_dec);
    acc  = dec_valid && dec_ready;
    xfr  = out_valid && out_ready;
    rs   = rst_dec_n;
    clr  = cnt_clr;
    code = dec_code;
    if (rs && out_valid) begin
      if (q.size() == 0) check("stale_out", 32'(out_valid), 32'd0);
      else check("out_word", {24'd0, dec_data, dec_syndrome, dec_err},
                 {24'd0, q[0].data, q[0].syn, q[0].err});
    end
    @(posedge clk_dec);
    cyc++;
    #1;
    last_acc = acc;
    if (!rs) begin
      q.delete();
      m_word = 0; m_err = 0; m_word_s = 0; m_err_s = 0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      if (xfr) begin
        if (q.size() == 0) begin
          check("xfer_empty_model", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
          if (!clr) begin
            m_word   = sat_inc(m_word, 255);
            m_word_s = sat_inc(m_word_s, 3);
            if (e.err) begin
              m_err   = sat_inc(m_err, 255);
              m_err_s = sat_inc(m_err_s, 3);
            end
          end
        end
      end
      if (clr) begin
        m_word = 0; m_err = 0; m_word_s = 0; m_err_s = 0;
      end
      if (acc) begin
        e     = ref_decode(code);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
    check("word_cnt", 32'(word_cnt), 32'(m_word));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("word_cnt_small", 32'(word_cnt_s), 32'(m_word_s));
    check("err_cnt_small", 32'(err_cnt_s), 32'(m_err_s));
  endtask

  task automatic send(input logic [7:1] c);
    dec_valid = 1'b1;
    dec_code  = c;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_acc) break;
    end
    check("accept_timeout", 32'(last_acc), 32'd1);
    dec_valid = 1'b0;
    dec_code  = 'x;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [7:1] c;
    logic [7:1] w[4];
    int         idx;

    rst_dec_n = 1'b0;
    dec_valid = 1'b0;
    dec_code  = 'x;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    idle(2);
    check("ready_in_reset", 32'(dec_ready), 32'd0);
    rst_dec_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(dec_ready), 32'd1);
    check("reset_data", {25'd0, out_valid, dec_data, dec_syndrome}, 32'd0);

    // All 16 clean codewords back to back, fixed two-cycle latency.
    lat_chk = 1'b1;
    for (int d = 0; d < 16; d++) send(encode(4'(d)));
    idle(4);
    lat_chk = 1'b0;
    check("clean_word_cnt", 32'(word_cnt), 32'd16);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);

    // A known word, then the same word with position 6 flipped.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    send(7'b1010101);
    send(7'b1110101);
    idle(1);
    check("pos6_data", 32'(dec_data), 32'hb);
    check("pos6_syndrome", 32'(dec_syndrome), 32'd6);
    idle(2);
    check("pos6_err_cnt", 32'(err_cnt), 32'd1);

    // Each position of the all-ones codeword flipped in turn.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int p = 1; p <= 7; p++) begin
      c    = 7'h7f;
      c[p] = 1'b0;
      send(c);
    end
    idle(4);
    check("flip_err_cnt", 32'(err_cnt), 32'd7);

    // Backpressure: only two words fit while the consumer stalls.
    for (int i = 0; i < 4; i++) w[i] = encode(4'(3 * i + 2));
    out_ready = 1'b0;
    dec_valid = 1'b1;
    idx       = 0;
    for (int k = 0; k < 5; k++) begin
      dec_code = w[idx];
      tick();
      if (last_acc) idx++;
    end
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_ready", 32'(dec_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      dec_code = w[idx];
      tick();
      if (last_acc) idx++;
    end
    dec_valid = 1'b0;
    dec_code  = 'x;
    idle(4);
    check("stall_drained", 32'(q.size()), 32'd0);

    // Saturation of the 2-bit counters, then clear during a transfer.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c    = encode(4'(i));
      c[7] = ~c[7];
      send(c);
    end
    idle(4);
    check("sat_err_cnt", 32'(err_cnt_s), 32'd3);
    check("sat_word_cnt", 32'(word_cnt_s), 32'd3);
    out_ready = 1'b0;
    send(encode(4'h9));
    idle(2);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr   = 1'b0;
    check("clr_xfer_word", 32'(word_cnt), 32'd0);
    check("clr_xfer_err_small", 32'(err_cnt_s), 32'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(encode(4'h5));
    send(encode(4'ha));
    rst_dec_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_cnt", {word_cnt, err_cnt}, 32'd0);
    rst_dec_n = 1'b1;
    #1;
    check("midrst_ready", 32'(dec_ready), 32'd1);
    out_ready = 1'b1;
    idle(4);
    check("no_stale_word", 32'(out_valid), 32'd0);

    // Random traffic: random valid/ready/clear, zero to two flipped bits per word.
    for (int k = 0; k < 600; k++) begin
      dec_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      cnt_clr   = ($urandom_range(63) == 0);
      c = encode(4'($urandom_range(15)));
      if ($urandom_range(1) == 1) c[$urandom_range(7, 1)] ^= 1'b1;
      if ($urandom_range(7) == 0) c[$urandom_range(7, 1)] ^= 1'b1;
      dec_code = dec_valid ? c : 'x;
      tick();
    end
    dec_valid = 1'b0;
    dec_code  = 'x;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    idle(5);
    check("random_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
